// File: rtl/varint_encoder.sv
// Protobuf base-128 varint serialiser: takes one 64-bit field value and emits
// its varint bytes, least-significant 7-bit group first, one byte per cycle.
module varint_encoder #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_val,
  input  logic             is_32,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic [LEN_W-1:0] out_idx
);

  localparam logic IDLE = 1'b0;
  localparam logic EMIT = 1'b1;

  logic             state_q, state_d;
  logic [63:0]      sh_q, sh_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [63:0]      load_val;
  logic             more;

  // 32-bit fields encode only the low word; the upper word is masked off at load.
  for (genvar gi = 0; gi < 64; gi++) begin : g_load
    if (gi < 32) begin : g_low
      assign load_val[gi] = in_val[gi];
    end else begin : g_high
      assign load_val[gi] = in_val[gi] & ~is_32;
    end
  end

  assign more      = |sh_q[63:7];
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_byte  = out_valid ? {more, sh_q[6:0]} : 8'h00;
  assign out_last  = out_valid & ~more;
  assign out_idx   = cnt_q;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sh_d    = load_val;
          cnt_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          sh_d  = sh_q >> 7;
          cnt_d = cnt_q + LEN_W'(1);
          if (!more) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_varint_encoder.sv
// Directed bench for varint_encoder: a queue-based reference encoder predicts
// every byte, and a negedge monitor compares the byte stream against it.
module tb_varint_encoder;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0] b;
    bit         last;
    int         idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_val = '0;
  logic        is_32 = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        out_last;
  logic [3:0]  out_idx;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [7:0] got[$];
  bit   expect_idle = 0;

  varint_encoder #(.LEN_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .is_32(is_32),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .out_idx(out_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: repeated division by 128; continuation set while a quotient remains.
  function automatic bq_t enc_bytes(input logic [63:0] v, input bit is32);
    bq_t q;
    logic [63:0] x;
    logic [63:0] rest;
    x = is32 ? (v % (64'd1 << 32)) : v;
    do begin
      rest = x / 128;
      q.push_back({(rest != 0), 7'(x % 128)});
      x = rest;
    end while (x != 0);
    return q;
  endfunction

  task automatic send(input logic [63:0] v, input bit is32);
    bq_t q;
    int n;
    q = enc_bytes(v, is32);
    foreach (q[i]) exp_q.push_back('{b: q[i], last: (i == q.size() - 1), idx: i});
    $display("send in_val=%h is_32=%0d expecting %0d bytes", v, is32, q.size());
    in_val   = v;
    is_32    = is32;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(n < 200), 64'd1);
  endtask

  task automatic chk_got(input string name, input int idx, input logic [7:0] req);
    if (idx < got.size()) chk(name, 64'(got[idx]), 64'(req));
    else chk(name, 64'hDEAD, 64'(req));
  endtask

  // Monitor: compares each presented byte against the model; pops on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (expect_idle) begin
        chk("gap_in_ready", 64'(in_ready), 64'd1);
        chk("gap_out_valid", 64'(out_valid), 64'd0);
        expect_idle = 0;
      end
      chk("in_ready_vs_out_valid", 64'(in_ready), 64'(!out_valid));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 64'(out_byte), 64'hFFFF);
        end else begin
          chk("out_byte", 64'(out_byte), 64'(exp_q[0].b));
          chk("out_last", 64'(out_last), 64'(exp_q[0].last));
          chk("out_idx", 64'(out_idx), 64'(exp_q[0].idx));
          if (out_ready) begin
            if (exp_q[0].last) expect_idle = 1;
            got.push_back(out_byte);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    bit pat[6];
    pat = '{1, 0, 0, 1, 0, 1};

    // Pin the reference encoder against hand-computed encodings.
    m = enc_bytes(64'd300, 1'b0);
    chk("model_300_len", 64'(m.size()), 64'd2);
    chk("model_300_b0", 64'(m[0]), 64'hAC);
    chk("model_300_b1", 64'(m[1]), 64'h02);
    m = enc_bytes(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk("model_32max_len", 64'(m.size()), 64'd5);
    chk("model_32max_b4", 64'(m[4]), 64'h0F);
    m = enc_bytes(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    chk("model_64max_len", 64'(m.size()), 64'd10);
    chk("model_64max_b9", 64'(m[9]), 64'h01);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_byte", 64'(out_byte), 64'h00);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_out_idx", 64'(out_idx), 64'd0);
    #2 rst_n = 1'b1;

    // Reset in the middle of a long varint.
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    expect_idle = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    got.delete();
    send(64'd1, 1'b0);
    drain();
    chk("after_rst_count", 64'(got.size()), 64'd1);
    chk_got("after_rst_b0", 0, 8'h01);

    got.delete();
    send(64'd300, 1'b0);
    drain();
    chk("v300_count", 64'(got.size()), 64'd2);
    chk_got("v300_b0", 0, 8'hAC);
    chk_got("v300_b1", 1, 8'h02);

    got.delete();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    drain();
    chk("v32max_count", 64'(got.size()), 64'd5);
    chk_got("v32max_b0", 0, 8'hFF);
    chk_got("v32max_b4", 4, 8'h0F);

    got.delete();
    send(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    drain();
    chk("v64max_count", 64'(got.size()), 64'd10);
    chk_got("v64max_b8", 8, 8'hFF);
    chk_got("v64max_b9", 9, 8'h01);

    // Back to back: upstream keeps in_valid high while the encoder is busy.
    got.delete();
    send(64'd0, 1'b0);
    send(64'd1, 1'b0);
    send(64'd127, 1'b0);
    drain();
    chk("b2b_count", 64'(got.size()), 64'd3);
    chk_got("b2b_b0", 0, 8'h00);
    chk_got("b2b_b1", 1, 8'h01);
    chk_got("b2b_b2", 2, 8'h7F);

    // Backpressure pattern; the monitor re-checks the held byte each stalled cycle.
    got.delete();
    send(64'd16384, 1'b0);
    foreach (pat[i]) begin
      out_ready = pat[i];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_count", 64'(got.size()), 64'd3);
    chk_got("bp_b0", 0, 8'h80);
    chk_got("bp_b1", 1, 8'h80);
    chk_got("bp_b2", 2, 8'h01);

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
